// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, filters the asynchronous locked
// indication, and releases the active-low system reset for the SHA256 core
// only after lock has held steadily. Loss of lock or a software request
// restarts the whole bring-up sequence.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int GLITCH_FILTER = 4,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             sw_reset,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    // The single timer counts 0..N-1 for whichever phase is active, so it
    // must hold the largest terminal value of all four phases.
    localparam int MAX_RT    = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_RTS   = (MAX_RT > STABLE_CYCLES) ? MAX_RT : STABLE_CYCLES;
    localparam int TIMER_MAX = (MAX_RTS > GLITCH_FILTER) ? MAX_RTS : GLITCH_FILTER;
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GLITCH_LAST  = TIMER_W'(GLITCH_FILTER - 1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic               sync_meta;
    logic               lk;
    logic               retry_inc;
    logic               loss_inc;

    assign state_o = state;

    // Two-flop synchronizer bringing the asynchronous locked flag into refclk.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            lk        <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            lk        <= sync_meta;
        end
    end

    // State and shared phase timer registers.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PLL_RST;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Next-state logic; sw_reset overrides every other transition, and the
    // timer restarts from zero whenever the state is (re)entered. In RUN the
    // timer doubles as the consecutive-low glitch counter.
    always_comb begin
        state_next = state;
        timer_next = timer + TIMER_W'(1);
        retry_inc  = 1'b0;
        loss_inc   = 1'b0;
        if (sw_reset) begin
            state_next = PLL_RST;
            timer_next = '0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (timer == RST_LAST) begin
                        state_next = WAIT_LOCK;
                        timer_next = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state_next = STABLE;
                        timer_next = '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        state_next = PLL_RST;
                        timer_next = '0;
                        retry_inc  = 1'b1;
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state_next = WAIT_LOCK;
                        timer_next = '0;
                    end else if (timer == STABLE_LAST) begin
                        state_next = RUN;
                        timer_next = '0;
                    end
                end
                RUN: begin
                    if (lk) begin
                        timer_next = '0;
                    end else if (timer == GLITCH_LAST) begin
                        state_next = PLL_RST;
                        timer_next = '0;
                        loss_inc   = 1'b1;
                    end
                end
                default: begin
                    state_next = PLL_RST;
                    timer_next = '0;
                end
            endcase
        end
    end

    // Saturating event counters; they only clear on rst_n.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            if (retry_inc && (retry_cnt != '1)) begin
                retry_cnt <= retry_cnt + CNT_W'(1);
            end
            if (loss_inc && (loss_cnt != '1)) begin
                loss_cnt <= loss_cnt + CNT_W'(1);
            end
        end
    end

    // Registered reset outputs decoded from the next state, so they change
    // on the same edge as the state and never glitch.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
        end else begin
            pll_rst   <= (state_next == PLL_RST);
            sys_rst_n <= (state_next == RUN);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: directed bring-up, timeout, glitch,
// sw_reset and async reset scenarios plus a randomized segment, all checked
// every cycle against a phase/dwell reference model.
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int GLITCH_FILTER = 2;
    localparam int CNT_W         = 4;
    localparam int CNT_MAX       = (1 << CNT_W) - 1;

    localparam int PH_PLL_RST = 0;
    localparam int PH_WAIT    = 1;
    localparam int PH_STABLE  = 2;
    localparam int PH_RUN     = 3;

    logic             refclk;
    logic             rst_n;
    logic             pll_locked;
    logic             sw_reset;
    logic             pll_rst;
    logic             sys_rst_n;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: current phase, edges spent in it, trailing low count
    // while running, counters, and the two-edge delay of the locked input.
    int mPhase;
    int mDwell;
    int mLowRun;
    int mRetry;
    int mLoss;
    bit mSync1;
    bit mLk;

    pll_lock_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .GLITCH_FILTER(GLITCH_FILTER),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .sw_reset  (sw_reset),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .state_o   (state_o),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    // 50 MHz reference clock.
    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    task automatic compareVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPhase  = PH_PLL_RST;
        mDwell  = 0;
        mLowRun = 0;
        mRetry  = 0;
        mLoss   = 0;
        mSync1  = 1'b0;
        mLk     = 1'b0;
    endtask

    task automatic modelEdge(input logic locked, input logic sw);
        int nxt;
        nxt = mPhase;
        if (sw) begin
            nxt = PH_PLL_RST;
        end else begin
            case (mPhase)
                PH_PLL_RST: if (mDwell + 1 >= RST_CYCLES) nxt = PH_WAIT;
                PH_WAIT: begin
                    if (mLk) nxt = PH_STABLE;
                    else if (mDwell + 1 >= LOCK_TIMEOUT) begin
                        nxt    = PH_PLL_RST;
                        mRetry = (mRetry < CNT_MAX) ? mRetry + 1 : CNT_MAX;
                    end
                end
                PH_STABLE: begin
                    if (!mLk) nxt = PH_WAIT;
                    else if (mDwell + 1 >= STABLE_CYCLES) nxt = PH_RUN;
                end
                default: begin
                    mLowRun = mLk ? 0 : mLowRun + 1;
                    if (mLowRun >= GLITCH_FILTER) begin
                        nxt   = PH_PLL_RST;
                        mLoss = (mLoss < CNT_MAX) ? mLoss + 1 : CNT_MAX;
                    end
                end
            endcase
        end
        if (sw || (nxt != mPhase)) begin
            mDwell  = 0;
            mLowRun = 0;
        end else begin
            mDwell++;
        end
        mPhase = nxt;
        mLk    = mSync1;
        mSync1 = locked;
    endtask

    task automatic checkOutput(input string tag);
        compareVal({tag, ".pll_rst"},   32'(pll_rst),   32'(mPhase == PH_PLL_RST));
        compareVal({tag, ".sys_rst_n"}, 32'(sys_rst_n), 32'(mPhase == PH_RUN));
        compareVal({tag, ".state_o"},   32'(state_o),   mPhase);
        compareVal({tag, ".retry_cnt"}, 32'(retry_cnt), mRetry);
        compareVal({tag, ".loss_cnt"},  32'(loss_cnt),  mLoss);
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check #1 later.
    task automatic applyStimulus(input logic locked, input logic sw, input string tag);
        pll_locked = locked;
        sw_reset   = sw;
        @(posedge refclk);
        modelEdge(locked, sw);
        #1;
        checkOutput(tag);
    endtask

    bit lvl;
    int len;
    int highs;
    bit reached;

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        sw_reset   = 1'b0;
        modelReset();
        repeat (3) @(posedge refclk);
        #1;
        checkOutput("reset");
        rst_n = 1'b1;

        // Bring-up: locked rises 10 cycles after release.
        repeat (10) applyStimulus(1'b0, 1'b0, "s1_low");
        repeat (10) applyStimulus(1'b1, 1'b0, "s1_lock");
        compareVal("s1_not_yet_run", 32'(state_o), 2);
        compareVal("s1_sys_still_low", 32'(sys_rst_n), 0);
        applyStimulus(1'b1, 1'b0, "s1_lock");
        compareVal("s1_run", 32'(state_o), 3);
        compareVal("s1_sys_high", 32'(sys_rst_n), 1);

        // One-cycle glitch ignored, three-cycle drop counted as loss.
        applyStimulus(1'b0, 1'b0, "s3_glitch");
        repeat (5) applyStimulus(1'b1, 1'b0, "s3_glitch_recover");
        compareVal("s3_glitch_state", 32'(state_o), 3);
        compareVal("s3_glitch_sys", 32'(sys_rst_n), 1);
        repeat (3) applyStimulus(1'b0, 1'b0, "s3_drop");
        applyStimulus(1'b1, 1'b0, "s3_drop_end");
        compareVal("s3_loss_state", 32'(state_o), 0);
        compareVal("s3_loss_sys", 32'(sys_rst_n), 0);
        compareVal("s3_loss_cnt", 32'(loss_cnt), 1);
        repeat (16) applyStimulus(1'b1, 1'b0, "s3_relock");
        compareVal("s3_relock_run", 32'(state_o), 3);

        // Lock drop inside STABLE after 5 good cycles restarts the count.
        applyStimulus(1'b1, 1'b1, "s4_sw");
        repeat (5) applyStimulus(1'b1, 1'b0, "s4_enter");
        compareVal("s4_in_stable", 32'(state_o), 2);
        repeat (3) applyStimulus(1'b1, 1'b0, "s4_good");
        applyStimulus(1'b0, 1'b0, "s4_dip");
        applyStimulus(1'b1, 1'b0, "s4_dip_sync");
        compareVal("s4_still_stable", 32'(state_o), 2);
        applyStimulus(1'b1, 1'b0, "s4_dip_seen");
        compareVal("s4_drop_state", 32'(state_o), 1);
        compareVal("s4_retry_unchanged", 32'(retry_cnt), 0);
        repeat (8) applyStimulus(1'b1, 1'b0, "s4_restart");
        compareVal("s4_restart_not_run", 32'(state_o), 2);
        applyStimulus(1'b1, 1'b0, "s4_restart");
        compareVal("s4_run", 32'(state_o), 3);

        // sw_reset on the same edge as the glitch-filter expiry.
        repeat (3) applyStimulus(1'b0, 1'b0, "s5_drop");
        applyStimulus(1'b0, 1'b1, "s5_sw");
        compareVal("s5_state", 32'(state_o), 0);
        compareVal("s5_pll_rst", 32'(pll_rst), 1);
        compareVal("s5_sys", 32'(sys_rst_n), 0);
        compareVal("s5_loss_unchanged", 32'(loss_cnt), 1);

        // Locked stays low: periodic PLL reset pulses and retry saturation.
        highs = 0;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, 1'b0, "s2_timeout");
            if (i < 240 && pll_rst === 1'b1) highs++;
        end
        compareVal("s2_rst_high_cycles", 32'(highs), 40);
        compareVal("s2_retry_sat", 32'(retry_cnt), CNT_MAX);

        // Randomized locked waveform with occasional sw_reset requests.
        for (int seg = 0; seg < 60; seg++) begin
            lvl = ($urandom_range(0, 3) != 0);
            len = lvl ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) begin
                applyStimulus(lvl, ($urandom_range(0, 49) == 0), "rand");
            end
        end

        // Asynchronous reset between clock edges while in STABLE.
        applyStimulus(1'b1, 1'b1, "s6_sw");
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            applyStimulus(1'b1, 1'b0, "s6_seek");
            if (mPhase == PH_STABLE) reached = 1'b1;
        end
        compareVal("s6_reach_stable", 32'(reached), 1);
        repeat (2) applyStimulus(1'b1, 1'b0, "s6_stable");
        #5;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("s6_async");
        compareVal("s6_async_pll_rst", 32'(pll_rst), 1);
        compareVal("s6_async_retry", 32'(retry_cnt), 0);
        @(posedge refclk);
        #1;
        checkOutput("s6_hold");
        rst_n = 1'b1;
        repeat (16) applyStimulus(1'b1, 1'b0, "s6_relock");
        compareVal("s6_relock_run", 32'(state_o), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
